// File: rtl/game_screen_ctl.sv
// game_screen_ctl -- SkyHop screen sequencer (START -> GAME -> OVER -> START).
// Drives the enables of the start screen, the game render chain and the
// game-over screen. Generates the shared 1 Hz blink tick and keeps the game
// time in seconds for the HUD and the over screen.
//
// Optional feature: define GAME_PAUSE_EN to add a PAUSE state that is entered
// and left with key_pause. key_space also leaves PAUSE.
//
// Ports:
//   clk           system/pixel clock, single domain
//   rst           asynchronous reset, active low (0 = reset)
//   key_space     1-cycle spacebar pulse
//   key_pause     1-cycle P-key pulse (used only with GAME_PAUSE_EN)
//   player_fall   1-cycle pulse, player lost
//   one_sec_tick  1-cycle pulse every CLK_FREQ_HZ cycles
//   start_en      start screen enable
//   game_en       game logic/render enable
//   over_en       game-over screen enable
//   game_rst      1-cycle pulse on GAME entry from START
//   time_sec      seconds elapsed in the current/last game
module game_screen_ctl #(
  parameter int unsigned CLK_FREQ_HZ   = 65_000_000,
  parameter int unsigned OVER_HOLD_SEC = 3,
  parameter int unsigned TIME_MAX      = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_space,
  input  logic       key_pause,
  input  logic       player_fall,
  output logic       one_sec_tick,
  output logic       start_en,
  output logic       game_en,
  output logic       over_en,
  output logic       game_rst,
  output logic [9:0] time_sec
);

  localparam int unsigned       CNT_W     = $clog2(CLK_FREQ_HZ);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_FREQ_HZ - 1);
  localparam logic [3:0]        HOLD_LAST = 4'(OVER_HOLD_SEC);
  localparam logic [9:0]        T_MAX     = 10'(TIME_MAX);

  typedef enum logic [1:0] {
    S_START,
    S_GAME,
`ifdef GAME_PAUSE_EN
    S_OVER,
    S_PAUSE
`else
    S_OVER
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       hold, hold_nxt;
  logic [9:0]       time_nxt;
  logic             tick_nxt, start_nxt, game_nxt, over_nxt, grst_nxt;
  logic             moving;

`ifndef GAME_PAUSE_EN
  logic unused_key_pause;
  assign unused_key_pause = key_pause;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_START: if (key_space) state_nxt = S_GAME;
      S_GAME: begin
        if (player_fall) state_nxt = S_OVER;
`ifdef GAME_PAUSE_EN
        else if (key_pause) state_nxt = S_PAUSE;
`endif
      end
      S_OVER: if (key_space && hold == HOLD_LAST) state_nxt = S_START;
`ifdef GAME_PAUSE_EN
      S_PAUSE: if (key_pause || key_space) state_nxt = S_GAME;
`endif
      default: state_nxt = S_START;
    endcase

    moving = (state_nxt != state);

    // A transition restarts the tick period, so a tick that would have
    // landed on the transition edge is dropped as well.
    tick_nxt = 1'b0;
    if (moving) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end

    hold_nxt = hold;
    if (state == S_GAME && state_nxt == S_OVER)
      hold_nxt = '0;
    else if (state == S_OVER && one_sec_tick && hold < HOLD_LAST)
      hold_nxt = hold + 4'd1;

    // The tick is counted even when player_fall leaves GAME on the same edge.
    time_nxt = time_sec;
    if (state == S_START && state_nxt == S_GAME)
      time_nxt = '0;
    else if (state == S_GAME && one_sec_tick && time_sec < T_MAX)
      time_nxt = time_sec + 10'd1;

    start_nxt = (state_nxt == S_START);
    game_nxt  = (state_nxt == S_GAME);
    over_nxt  = (state_nxt == S_OVER);
    grst_nxt  = (state == S_START) && (state_nxt == S_GAME);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_START;
      cnt          <= '0;
      hold         <= '0;
      time_sec     <= '0;
      one_sec_tick <= 1'b0;
      start_en     <= 1'b1;
      game_en      <= 1'b0;
      over_en      <= 1'b0;
      game_rst     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hold         <= hold_nxt;
      time_sec     <= time_nxt;
      one_sec_tick <= tick_nxt;
      start_en     <= start_nxt;
      game_en      <= game_nxt;
      over_en      <= over_nxt;
      game_rst     <= grst_nxt;
    end
  end

endmodule

// File: tb/tb_game_screen_ctl.sv
// Directed bench for game_screen_ctl with CLK_FREQ_HZ=10, OVER_HOLD_SEC=2,
// TIME_MAX=5. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, i.e. just after the edge that produced them.
module tb_game_screen_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_space = 1'b0;
  logic       key_pause = 1'b0;
  logic       player_fall = 1'b0;
  logic       one_sec_tick, start_en, game_en, over_en, game_rst;
  logic [9:0] time_sec;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  game_screen_ctl #(
    .CLK_FREQ_HZ  (10),
    .OVER_HOLD_SEC(2),
    .TIME_MAX     (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_space   (key_space),
    .key_pause   (key_pause),
    .player_fall (player_fall),
    .one_sec_tick(one_sec_tick),
    .start_en    (start_en),
    .game_en     (game_en),
    .over_en     (over_en),
    .game_rst    (game_rst),
    .time_sec    (time_sec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until one_sec_tick is seen high, bounded at 50.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!one_sec_tick && cnt < 50);
  endtask

  task automatic pulse_space();
    key_space = 1'b1; step(1); key_space = 1'b0;
  endtask

  task automatic pulse_fall();
    player_fall = 1'b1; step(1); player_fall = 1'b0;
  endtask

  task automatic pulse_pause();
    key_pause = 1'b1; step(1); key_pause = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and tick phase after release
    #2 rst = 1'b0;
    step(3);
    check("rst_start_en", start_en, 1);
    check("rst_game_en", game_en, 0);
    check("rst_over_en", over_en, 0);
    check("rst_game_rst", game_rst, 0);
    check("rst_tick", one_sec_tick, 0);
    check("rst_time", time_sec, 0);
    rst = 1'b1;
    wait_tick(n);
    check("first_tick_gap", n, 10);
    wait_tick(n);
    check("second_tick_gap", n, 10);

    // START -> GAME
    pulse_space();
    check("g_game_en", game_en, 1);
    check("g_start_en", start_en, 0);
    check("g_game_rst", game_rst, 1);
    check("g_time0", time_sec, 0);
    check("g_tick_dropped", one_sec_tick, 0);
    step(1);
    check("g_game_rst_1cyc", game_rst, 0);
    wait_tick(n);
    check("g_tick_gap", n, 9);
    step(1);
    check("g_time1", time_sec, 1);

    // Saturation, then GAME -> OVER
    step(70);
    check("sat_time", time_sec, 5);
    pulse_fall();
    check("o_over_en", over_en, 1);
    check("o_game_en", game_en, 0);
    check("o_time", time_sec, 5);

    // Early key_space in OVER is dropped, late one is accepted
    step(14);
    pulse_space();
    check("o_early_over_en", over_en, 1);
    check("o_early_start_en", start_en, 0);
    step(9);
    pulse_space();
    check("o_late_start_en", start_en, 1);
    check("o_late_over_en", over_en, 0);
    check("s_time_kept", time_sec, 5);

    // player_fall coincident with a tick
    pulse_space();
    check("g2_game_en", game_en, 1);
    check("g2_time0", time_sec, 0);
    step(30);
    check("g2_tick", one_sec_tick, 1);
    check("g2_time2", time_sec, 2);
    pulse_fall();
    check("g2_time3", time_sec, 3);
    check("g2_over_en", over_en, 1);

    // Pause behaviour
    step(24);
    pulse_space();
    check("g3_start_en", start_en, 1);
    pulse_space();
    check("g3_game_en", game_en, 1);
    step(11);
    check("g3_time1", time_sec, 1);
    pulse_pause();
`ifdef GAME_PAUSE_EN
    check("p_game_en", game_en, 0);
    check("p_start_en", start_en, 0);
    check("p_over_en", over_en, 0);
    step(30);
    check("p_time_frozen", time_sec, 1);
    check("p_game_en_held", game_en, 0);
    pulse_space();
    check("p_resume_game_en", game_en, 1);
    check("p_resume_game_rst", game_rst, 0);
    check("p_resume_time", time_sec, 1);
    step(11);
    check("p_time_continues", time_sec, 2);
`else
    check("np_game_en", game_en, 1);
    step(30);
    check("np_time", time_sec, 4);
    pulse_space();
    check("np_space_ignored", game_en, 1);
    check("np_game_rst", game_rst, 0);
    step(11);
    check("np_time_sat", time_sec, 5);
`endif

    // Asynchronous reset in the middle of a game
    #2 rst = 1'b0;
    #1;
    check("ar_start_en", start_en, 1);
    check("ar_game_en", game_en, 0);
    check("ar_over_en", over_en, 0);
    check("ar_time", time_sec, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_tick(n);
    check("ar_tick_gap", n, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
